// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode, FSM state and flag index definitions for the ALU datapath
package alu_pkg;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd6;
  localparam logic [2:0] ALU_MUL  = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_CARRY   = 1;
  localparam int FLAG_OVF     = 2;
  localparam int FLAG_ILLEGAL = 3;
  localparam int FLAG_W       = 4;
endpackage

// File: rtl/alu_comb_nb.sv
// alu_comb_nb: combinational ADD..SLTU with carry/borrow and signed overflow
module alu_comb_nb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_r,
  output logic             o_carry,
  output logic             o_ovf
);
  logic [WIDTH:0] w_sum, w_dif;
  logic           w_slt;
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};
  // differing signs: a is less exactly when it is negative; otherwise the borrow decides
  assign w_slt = (i_a[WIDTH-1] != i_b[WIDTH-1]) ? i_a[WIDTH-1] : w_dif[WIDTH];
  always_comb begin
    o_r     = '0;
    o_carry = 1'b0;
    o_ovf   = 1'b0;
    case (i_op)
      ALU_ADD: begin
        o_r     = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
        o_ovf   = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_SUB: begin
        o_r     = w_dif[WIDTH-1:0];
        o_carry = w_dif[WIDTH];
        o_ovf   = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_dif[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND:  o_r = i_a & i_b;
      ALU_OR:   o_r = i_a | i_b;
      ALU_XOR:  o_r = i_a ^ i_b;
      ALU_SLT:  o_r = WIDTH'(w_slt);
      ALU_SLTU: o_r = WIDTH'(w_dif[WIDTH]);
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_seq_nb.sv
// alu_seq_nb: registered valid/ready ALU with multi-cycle shift-add multiply
module alu_seq_nb
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             illegal
);
  state_t             r_state, w_next;
  logic               w_acc, w_is_mul, w_mul_op, w_mul_last, w_carry, w_ovf;
  logic [WIDTH-1:0]   w_r, r_r;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               r_zero, r_carry, r_ovf, r_illegal;
  assign in_ready  = rst_n && (r_state == IDLE || (r_state == HOLD && out_ready));
  assign out_valid = r_state == HOLD;
  assign w_acc     = in_valid && in_ready;
  assign w_is_mul  = opcode == ALU_MUL;
  assign w_mul_op  = w_is_mul && MUL_EN;
  assign r         = r_r;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;
  alu_comb_nb #(.WIDTH(WIDTH)) u_comb (
    .i_a    (a),
    .i_b    (b),
    .i_op   (opcode),
    .o_r    (w_r),
    .o_carry(w_carry),
    .o_ovf  (w_ovf)
  );
  generate
    if (MUL_EN) begin : g_mul
      localparam int CW = $clog2(WIDTH);
      logic [2*WIDTH-1:0] r_acc, r_bsh;
      logic [WIDTH-1:0]   r_ash;
      logic [CW-1:0]      r_cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
          r_ash <= '0;
          r_bsh <= '0;
          r_cnt <= '0;
        end else if (w_acc && w_mul_op) begin
          r_acc <= '0;
          r_ash <= a;
          r_bsh <= {{WIDTH{1'b0}}, b};
          r_cnt <= '0;
        end else if (r_state == MUL) begin
          r_acc <= w_acc_nxt;
          r_ash <= r_ash >> 1;
          r_bsh <= r_bsh << 1;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      assign w_acc_nxt  = r_acc + (r_ash[0] ? r_bsh : '0);
      assign w_mul_last = r_cnt == CW'(WIDTH - 1);
    end else begin : g_nomul
      assign w_acc_nxt  = '0;
      assign w_mul_last = 1'b0;
    end
  endgenerate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (w_acc) w_next = w_mul_op ? MUL : HOLD;
    else if (r_state == MUL && w_mul_last) w_next = HOLD;
    else if (r_state == HOLD && out_ready) w_next = IDLE;
  end
  // opcode 111 without a multiplier falls through the comb unit as r=0, flags clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r       <= '0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_acc && !w_mul_op) begin
      r_r       <= w_r;
      r_zero    <= w_r == '0;
      r_carry   <= w_carry;
      r_ovf     <= w_ovf;
      r_illegal <= w_is_mul;
    end else if (r_state == MUL && w_mul_last) begin
      r_r       <= w_acc_nxt[WIDTH-1:0];
      r_zero    <= w_acc_nxt[WIDTH-1:0] == '0;
      r_carry   <= 1'b0;
      r_ovf     <= |w_acc_nxt[2*WIDTH-1:WIDTH];
      r_illegal <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq_nb.sv
// tb_alu_seq_nb: scoreboard bench for alu_seq_nb with and without the multiplier
module tb_alu_seq_nb;
  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       c;
    logic       o;
    logic       i;
  } exp_t;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       in_valid = 1'b0, in_valid0 = 1'b0, out_ready = 1'b1;
  logic [7:0] a = '0, b = '0;
  logic [2:0] opcode = '0;
  logic       in_ready, out_valid, zero, carry, ovf, illegal;
  logic       in_ready0, out_valid0, zero0, carry0, ovf0, illegal0;
  logic [7:0] r, r0;
  exp_t       q[$], q0[$];
  exp_t       em, em0;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  alu_seq_nb #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .zero(zero), .carry(carry), .ovf(ovf), .illegal(illegal)
  );
  alu_seq_nb #(.WIDTH(8), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid0), .out_ready(out_ready),
    .r(r0), .zero(zero0), .carry(carry0), .ovf(ovf0), .illegal(illegal0)
  );
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected got r=%h flags=%b with nothing expected", r, {zero, carry, ovf, illegal});
      end else begin
        em = q.pop_front();
        if ({r, zero, carry, ovf, illegal} !== em) begin
          errors++;
          $display("FAIL result got r=%h zcoi=%b expected r=%h zcoi=%b", r, {zero, carry, ovf, illegal}, em.r, {em.z, em.c, em.o, em.i});
        end
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL result0_unexpected got r=%h flags=%b with nothing expected", r0, {zero0, carry0, ovf0, illegal0});
      end else begin
        em0 = q0.pop_front();
        if ({r0, zero0, carry0, ovf0, illegal0} !== em0) begin
          errors++;
          $display("FAIL result0 got r=%h zcoi=%b expected r=%h zcoi=%b", r0, {zero0, carry0, ovf0, illegal0}, em0.r, {em0.z, em0.c, em0.o, em0.i});
        end
      end
    end
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input bit sel, input logic [7:0] a_, input logic [7:0] b_, input logic [2:0] op_, input bit push, input exp_t e);
    int t = 0;
    a = a_;
    b = b_;
    opcode = op_;
    if (sel) in_valid0 = 1'b1;
    else in_valid = 1'b1;
    if (push) begin
      if (sel) q0.push_back(e);
      else q.push_back(e);
    end
    @(negedge clk);
    while (!(sel ? in_ready0 : in_ready) && t < 50) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0d in_ready stayed 0", op_);
      if (push) begin
        if (sel) void'(q0.pop_back());
        else void'(q.pop_back());
      end
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid0 = 1'b0;
  endtask
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    exp_t e;
    int   s, sv;
    e = '0;
    case (op)
      3'd0: begin
        s = int'(x) + int'(y);
        sv = int'($signed(x)) + int'($signed(y));
        e.r = s[7:0];
        e.c = s > 255;
        e.o = sv > 127 || sv < -128;
      end
      3'd1: begin
        s = int'(x) - int'(y);
        sv = int'($signed(x)) - int'($signed(y));
        e.r = s[7:0];
        e.c = x < y;
        e.o = sv > 127 || sv < -128;
      end
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: e.r = {7'b0, int'($signed(x)) < int'($signed(y))};
      3'd6: e.r = {7'b0, x < y};
      default: e.i = 1'b1;
    endcase
    e.z = e.r == 8'h00;
    return e;
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [7:0] x, y;
    logic [2:0] op;
    #22;
    chk("reset_outputs", {31'b0, out_valid} | {23'b0, r, zero} | {28'b0, carry, ovf, illegal, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    chk("ready_after_reset", {31'b0, in_ready}, 32'h1);
    issue(0, 8'hFF, 8'h01, 3'd0, 1, {8'h00, 4'b1100});
    chk("add_latency", {31'b0, out_valid}, 32'h1);
    issue(0, 8'h80, 8'h01, 3'd1, 1, {8'h7F, 4'b0010});
    issue(0, 8'hFF, 8'h01, 3'd5, 1, {8'h01, 4'b0000});
    issue(0, 8'hFF, 8'h01, 3'd6, 1, {8'h00, 4'b1000});
    issue(0, 8'hF0, 8'h3C, 3'd2, 1, {8'h30, 4'b0000});
    issue(0, 8'hAA, 8'hFF, 3'd4, 1, {8'h55, 4'b0000});
    issue(0, 8'h5A, 8'h5A, 3'd4, 1, {8'h00, 4'b1000});
    issue(0, 8'h7F, 8'h01, 3'd0, 1, {8'h80, 4'b0010});
    issue(0, 8'h01, 8'h02, 3'd1, 1, {8'hFF, 4'b0100});
    issue(0, 8'hF0, 8'h0C, 3'd3, 1, {8'hFC, 4'b0000});
    idle(2);
    issue(0, 8'd13, 8'd11, 3'd7, 1, {8'h8F, 4'b0000});
    chk("mul_in_ready_busy", {31'b0, in_ready}, 32'h0);
    n = 1;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mul_latency", n, 9);
    issue(0, 8'h10, 8'h10, 3'd7, 1, {8'h00, 4'b1010});
    issue(0, 8'hFF, 8'hFF, 3'd7, 1, {8'h01, 4'b0010});
    idle(12);
    out_ready = 1'b0;
    issue(0, 8'h12, 8'h34, 3'd0, 1, {8'h46, 4'b0000});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_stable", {22'b0, out_valid, r, zero, carry, ovf, illegal, in_ready}, {22'b0, 1'b1, 8'h46, 4'b0000, 1'b0});
    end
    @(posedge clk);
    #1;
    a = 8'h0F;
    b = 8'hA0;
    opcode = 3'd3;
    in_valid = 1'b1;
    q.push_back({8'hAF, 4'b0000});
    @(negedge clk);
    chk("queued_blocked", {31'b0, in_ready}, 32'h0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("queued_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("queued_result", {23'b0, out_valid, r}, {23'b0, 1'b1, 8'hAF});
    idle(2);
    issue(0, 8'd13, 8'd11, 3'd7, 0, '0);
    idle(3);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_mul", {22'b0, out_valid, r, zero, carry, ovf, illegal, in_ready}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("no_result_after_abort", n, 0);
    chk("ready_after_abort", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    issue(0, 8'h01, 8'h02, 3'd0, 1, {8'h03, 4'b0000});
    idle(2);
    issue(1, 8'h05, 8'h07, 3'd7, 1, {8'h00, 4'b1001});
    chk("illegal_latency", {30'b0, out_valid0, illegal0}, 32'h3);
    for (int k = 0; k < 16; k++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      op = 3'($urandom_range(0, 6));
      issue(1, x, y, op, 1, model(x, y, op));
    end
    idle(4);
    chk("queue_drained", q.size(), 0);
    chk("queue0_drained", q0.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
